// File: rtl/ntt_addr_ctrl_pkg.sv
// Shared constants, FSM state type and the butterfly pair-address helper
// for the NTT address controller.
package ntt_pkg;
  localparam int AWID   = 7;
  localparam int NPAIR  = 64;
  localparam int NSTAGE = 7;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} ntt_state_e;

  typedef struct packed {
    logic [AWID-1:0] a;
    logic [AWID-1:0] b;
    logic [AWID-1:0] tw;
  } pair_t;

  // NTT halves the butterfly span each stage, INTT doubles it.
  function automatic pair_t pair_addr(input logic [2:0] stage, input logic mode,
                                      input logic [5:0] p);
    logic [2:0] l;
    logic [7:0] len;
    logic [7:0] grp;
    logic [7:0] a;
    logic [7:0] tw;
    pair_t      r;
    l    = mode ? stage : 3'd6 - stage;
    len  = 8'd1 << l;
    grp  = {2'b00, p} >> l;
    a    = ((grp << l) << 1) | ({2'b00, p} & (len - 8'd1));
    tw   = mode ? (8'd128 >> stage) - 8'd1 - grp : (8'd1 << stage) + grp;
    r.a  = AWID'(a);
    r.b  = AWID'(a + len);
    r.tw = AWID'(tw);
    return r;
  endfunction
endpackage

// File: rtl/ntt_addr_ctrl_if.sv
// Control bus between the NTT address controller and its environment:
// start/mode in, RAM addresses/enables, butterfly qualifiers and status out.
interface ntt_addr_ctrl_if;
  import ntt_pkg::*;

  // rd_valid is a pure qualifier with no ready: the butterfly must consume
  // DA1out/DB1out together with tw_idx and mode_q in the cycle it is high.
  logic             start;
  logic             mode;
  logic [AWID-1:0]  A1radd;
  logic [AWID-1:0]  B1radd;
  logic             we1;
  logic             we2;
  logic             rd_valid;
  logic [AWID-1:0]  tw_idx;
  logic             mode_q;
  logic             busy;
  logic             done;
  ntt_state_e       state_dbg;

  modport master (
    output start, mode,
    input  A1radd, B1radd, we1, we2, rd_valid, tw_idx, mode_q, busy, done, state_dbg
  );

  modport slave (
    input  start, mode,
    output A1radd, B1radd, we1, we2, rd_valid, tw_idx, mode_q, busy, done, state_dbg
  );
endinterface

// File: rtl/ntt_addr_ctrl_addr_delay.sv
// Fixed-depth shift register that replays read addresses as write-back
// addresses once the butterfly result is ready.
module addr_delay #(
  parameter int DEPTH = 5,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  output logic          out_valid,
  output logic [AW-1:0] out_a,
  output logic [AW-1:0] out_b,
  output logic          pending
);
  logic [DEPTH-1:0]         v_q;
  logic [DEPTH-1:0][AW-1:0] a_q;
  logic [DEPTH-1:0][AW-1:0] b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      v_q <= {v_q[DEPTH-2:0], in_valid};
      a_q <= {a_q[DEPTH-2:0], in_a};
      b_q <= {b_q[DEPTH-2:0], in_b};
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];
  // Writes still in flight beyond the one leaving this cycle.
  assign pending   = |v_q[DEPTH-2:0];
endmodule

// File: rtl/ntt_addr_ctrl.sv
// Address/control sequencer for an in-place 128-point NTT/INTT: issues pair
// reads on even phases and replays them as writes 1+BF_LAT cycles later.
module ntt_addr_ctrl
  import ntt_pkg::*;
#(
  parameter int BF_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  ntt_addr_ctrl_if.slave bus
);
  localparam int         DEPTH      = 1 + BF_LAT;
  localparam logic [6:0] LAST_PHASE = 7'(2 * NPAIR - 1);
  localparam logic [2:0] LAST_STAGE = 3'(NSTAGE - 1);

  ntt_state_e      state;
  ntt_state_e      state_nxt;
  logic [2:0]      stage;
  logic [6:0]      phase;
  logic            mode_r;
  logic            rd_valid_r;
  logic [AWID-1:0] tw_r;
  logic [AWID-1:0] a_hold;
  logic [AWID-1:0] b_hold;
  logic [AWID-1:0] a_out;
  logic [AWID-1:0] b_out;
  logic            read_issue;
  logic            accept;
  logic            pending;
  logic            wr_valid;
  logic [AWID-1:0] wr_a;
  logic [AWID-1:0] wr_b;
  pair_t           pr;

  // Pair counter p is the phase with its parity bit dropped.
  assign pr = pair_addr(stage, mode_r, phase[6:1]);

  always_comb begin
    state_nxt  = state;
    read_issue = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = READ;
          accept    = 1'b1;
        end
      end
      READ: begin
        read_issue = ~phase[0];
        if (phase == LAST_PHASE) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!pending) state_nxt = (stage == LAST_STAGE) ? FIN : READ;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage  <= '0;
      phase  <= '0;
      mode_r <= 1'b0;
    end else if (accept) begin
      stage  <= '0;
      phase  <= '0;
      mode_r <= bus.mode;
    end else if (state == READ) begin
      phase <= phase + 7'd1;
    end else if (state == DRAIN && !pending && stage != LAST_STAGE) begin
      stage <= stage + 3'd1;
    end
  end

  addr_delay #(.DEPTH(DEPTH), .AW(AWID)) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (read_issue),
    .in_a      (pr.a),
    .in_b      (pr.b),
    .out_valid (wr_valid),
    .out_a     (wr_a),
    .out_b     (wr_b),
    .pending   (pending)
  );

  // Reads sit on even phases and writes on odd ones, so the two never coincide.
  always_comb begin
    a_out = a_hold;
    b_out = b_hold;
    if (wr_valid) begin
      a_out = wr_a;
      b_out = wr_b;
    end else if (read_issue) begin
      a_out = pr.a;
      b_out = pr.b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_hold     <= '0;
      b_hold     <= '0;
      rd_valid_r <= 1'b0;
      tw_r       <= '0;
    end else begin
      a_hold     <= a_out;
      b_hold     <= b_out;
      rd_valid_r <= read_issue;
      if (read_issue) tw_r <= pr.tw;
    end
  end

  assign bus.A1radd    = a_out;
  assign bus.B1radd    = b_out;
  assign bus.we1       = wr_valid;
  assign bus.we2       = wr_valid;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.tw_idx    = tw_r;
  assign bus.mode_q    = mode_r;
  assign bus.busy      = (state == READ) || (state == DRAIN);
  assign bus.done      = (state == FIN);
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_ntt_addr_ctrl.sv
// Bench for ntt_addr_ctrl: randomized NTT/INTT runs scored against a
// division-based model of the pair address, twiddle and timing rules.
`timescale 1ns/1ps
module tb_ntt_addr_ctrl;
  import ntt_pkg::*;

  localparam int BF_LAT = 4;
  localparam int SLEN   = 128 + BF_LAT;
  localparam int WW     = 49;
  localparam int RW     = 55;
  localparam int SW     = 47;

  logic clk = 1'b0;
  logic rst;
  int   gcyc     = 0;
  int   n_checks = 0;
  int   n_fails  = 0;

  logic [WW-1:0] exp_wr_q[$];
  logic [RW-1:0] exp_rd_q[$];
  logic [SW-1:0] exp_spot_q[$];
  logic [31:0]   exp_done_q[$];

  ntt_addr_ctrl_if bus();

  ntt_addr_ctrl #(.BF_LAT(BF_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, gcyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s @cycle %0d: bound expired", name, gcyc);
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_pair(input int s, input int m, input int p,
                                   output int a, output int b, output int tw);
    int len;
    len = (m != 0) ? (1 << s) : (64 >> s);
    a   = (p / len) * 2 * len + (p % len);
    b   = a + len;
    tw  = (m != 0) ? (128 >> s) - 1 - p / len : (1 << s) + p / len;
  endfunction

  task automatic push_expect(input int t0, input logic m);
    int a, b, tw, rc;
    for (int s = 0; s < 7; s++) begin
      for (int p = 0; p < 64; p++) begin
        ref_pair(s, int'(m), p, a, b, tw);
        rc = t0 + s * SLEN + 2 * p;
        exp_rd_q.push_back({32'(rc + 1), 7'(a), 7'(b), 1'b0, 7'(tw), m});
        exp_wr_q.push_back({32'(rc + 1 + BF_LAT), 7'(a), 7'(b), 3'b111});
      end
    end
    exp_done_q.push_back(32'(t0 + 7 * SLEN));
  endtask

  task automatic push_spots(input int t0, input logic m);
    if (!m) begin
      exp_spot_q.push_back({32'(t0),       7'd0, 7'd64, 1'b0});
      exp_spot_q.push_back({32'(t0 + 2),   7'd1, 7'd65, 1'b0});
      exp_spot_q.push_back({32'(t0 + 5),   7'd0, 7'd64, 1'b1});
      exp_spot_q.push_back({32'(t0 + 132), 7'd0, 7'd32, 1'b0});
    end else begin
      exp_spot_q.push_back({32'(t0),       7'd0, 7'd1,  1'b0});
      exp_spot_q.push_back({32'(t0 + 2),   7'd2, 7'd3,  1'b0});
      exp_spot_q.push_back({32'(t0 + 792), 7'd0, 7'd64, 1'b0});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [6:0] h1_a, h1_b, h2_a, h2_b;
  logic       h1_we;
  logic       h1_v = 1'b0;
  logic       h2_v = 1'b0;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      h1_v      = 1'b0;
      h2_v      = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.we1 || bus.we2) begin
        if (exp_wr_q.size() == 0)
          chk("unexpected_write", 64'({bus.we1, bus.we2}), 64'd0);
        else
          chk("write", 64'({32'(gcyc), bus.A1radd, bus.B1radd, bus.we1, bus.we2, bus.busy}),
              64'(exp_wr_q.pop_front()));
      end
      if (bus.rd_valid) begin
        if (exp_rd_q.size() == 0)
          chk("unexpected_rd_valid", 64'(bus.rd_valid), 64'd0);
        else
          chk("read", 64'({32'(gcyc), h1_a, h1_b, h1_we, bus.tw_idx, bus.mode_q}),
              64'(exp_rd_q.pop_front()));
      end
      if (bus.done) begin
        if (exp_done_q.size() == 0)
          chk("unexpected_done", 64'(bus.done), 64'd0);
        else
          chk("done", 64'({32'(gcyc), bus.busy}), 64'({exp_done_q.pop_front(), 1'b0}));
      end
      if (prev_done) chk("idle_after_done", 64'(bus.state_dbg), 64'(IDLE));
      if (exp_spot_q.size() != 0 && exp_spot_q[0][SW-1:SW-32] == 32'(gcyc))
        chk("spot", 64'({32'(gcyc), bus.A1radd, bus.B1radd, bus.we1}), 64'(exp_spot_q.pop_front()));
      // Previous cycle had neither a write nor a read: its address must equal the one before.
      if (h1_v && h2_v && !h1_we && !bus.rd_valid)
        chk("addr_hold", 64'({h1_a, h1_b}), 64'({h2_a, h2_b}));
      h2_v      = h1_v;
      h2_a      = h1_a;
      h2_b      = h1_b;
      h1_v      = 1'b1;
      h1_a      = bus.A1radd;
      h1_b      = bus.B1radd;
      h1_we     = bus.we1;
      prev_done = bus.done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while ((bus.busy || bus.done) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) fail_now("idle_timeout");
  endtask

  task automatic run(input logic m, input bit spots, input int ign_at, input int rst_at,
                     input bit noise);
    int t0;
    bit fin;
    wait_idle();
    repeat ($urandom_range(0, 4)) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b1;
    bus.mode  = m;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t0 = gcyc;
    chk("busy_at_cycle0", 64'({bus.busy, bus.done}), 64'b10);
    push_expect(t0, m);
    if (spots) push_spots(t0, m);
    fin = 1'b0;
    for (int n = 0; n < 1200 && !fin; n++) begin
      bus.start = noise ? ($urandom_range(0, 15) == 0) : 1'b0;
      bus.mode  = 1'($urandom_range(0, 1));
      if (ign_at >= 0 && gcyc == t0 + ign_at) begin
        bus.start = 1'b1;
        bus.mode  = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rst_at >= 0 && gcyc == t0 + rst_at) begin
        bus.start = 1'b0;
        rst       = 1'b0;
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_spot_q.delete();
        exp_done_q.delete();
        #1;
        chk("reset_we", 64'({bus.we1, bus.we2}), 64'd0);
        chk("reset_outputs", 64'({bus.A1radd, bus.B1radd, bus.rd_valid, bus.tw_idx,
                                  bus.mode_q, bus.busy, bus.done}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        fin = 1'b1;
      end else if (bus.done) begin
        bus.start = 1'b0;
        fin       = 1'b1;
      end
    end
    bus.start = 1'b0;
    if (!fin) fail_now("run_timeout");
    if (rst_at < 0) begin
      @(negedge clk);
      #1;
      chk("queues_drained", 64'({16'(exp_wr_q.size()), 16'(exp_rd_q.size()),
                                 16'(exp_spot_q.size()), 16'(exp_done_q.size())}), 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_we", 64'({bus.we1, bus.we2}), 64'd0);
    chk("reset_status", 64'({bus.busy, bus.done, bus.rd_valid}), 64'd0);
    chk("reset_addr", 64'({bus.A1radd, bus.B1radd}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run(1'b0, 1'b1, -1, -1, 1'b0);
    run(1'b1, 1'b1, -1, -1, 1'b0);
    run(1'b0, 1'b0, 300, -1, 1'b0);
    run(1'b0, 1'b0, -1, 400, 1'b0);
    run(1'b0, 1'b1, -1, -1, 1'b0);
    run(1'($urandom_range(0, 1)), 1'b0, -1, -1, 1'b1);
    run(1'($urandom_range(0, 1)), 1'b0, -1, int'($urandom_range(1, 900)), 1'b1);
    run(1'($urandom_range(0, 1)), 1'b0, -1, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #600000;
    n_checks++;
    n_fails++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ntt_addr_ctrl.md
NTT_ADDR_CTRL -- requirements
Module: ntt_addr_ctrl

Interface
REQ-001 The block SHALL have parameter BF_LAT, default 4, which is the butterfly pipeline latency in cycles; it must be even and at least 2.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset: port clk is the clock and port rst is the reset, active-low and asynchronous.
REQ-003 clk  input  1  Rising-edge clock shared with the coefficient RAM and the butterfly.
REQ-004 rst  input  1  Asynchronous active-low reset.
REQ-005 start  input  1  Begin a transform; sampled in IDLE only.
REQ-006 mode  input  1  Transform direction: 0 = NTT, 1 = INTT; latched when start is accepted.
REQ-007 A1radd  output  7  RAM port A address, used for both read and write.
REQ-008 B1radd  output  7  RAM port B address, used for both read and write.
REQ-009 we1  output  1  RAM port A write enable.
REQ-010 we2  output  1  RAM port B write enable; always equal to we1.
REQ-011 rd_valid  output  1  Asserted when RAM DA1out/DB1out hold a valid butterfly input pair.
REQ-012 tw_idx  output  7  Twiddle (zeta) index, aligned with rd_valid.
REQ-013 mode_q  output  1  Latched mode, passed to the butterfly.
REQ-014 busy  output  1  High from start acceptance through the cycle of the final write.
REQ-015 done  output  1  One-cycle pulse in the cycle after the final write.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, READ, DRAIN, FIN.
REQ-017 FSM transitions SHALL be: IDLE->READ on start; READ->DRAIN after 64 read issues; DRAIN->READ when the write pipeline is empty and stage<6; DRAIN->FIN when the pipeline is empty and stage=6; FIN->IDLE unconditionally.
REQ-018 Cycle numbering SHALL be: cycle 0 is the cycle after start is sampled; stage s begins at cycle s*(128+BF_LAT).
REQ-019 In READ, reads SHALL be issued on even phase cycles only, with pair counter p = 0..63 incrementing once per read, and we1=we2=0.
REQ-020 Each stage SHALL use L=log2(len): NTT uses len=64>>s and INTT uses len=1<<s.
REQ-021 Pair addresses SHALL be A=((p>>L)<<(L+1))|(p&(len-1)) and B=A+len, using 7-bit arithmetic with no wrap.
REQ-022 tw_idx SHALL be (1<<s)+(p>>L) for NTT and (128>>s)-1-(p>>L) for INTT; its range is always 1..127.
REQ-023 rd_valid and tw_idx SHALL be asserted exactly 1 cycle after the corresponding read issue, matching the registered RAM read.
REQ-024 Write-back SHALL occur 1+BF_LAT cycles after the read issue: A1radd/B1radd SHALL carry the delayed A/B addresses and we1=we2=1.
REQ-025 Because 1+BF_LAT is odd, writes always fall on odd phase cycles, so read and write never collide on a port; the block SHALL rely on this parity rule.
REQ-026 A stage SHALL NOT issue reads until every write of the previous stage has occurred (RAW hazard across stages).
REQ-027 On cycles with neither a read nor a write, address outputs SHALL hold their values and we1=we2=0.
REQ-028 start asserted while busy=1 SHALL be ignored; mode changes while busy SHALL be ignored.
REQ-029 Total latency SHALL be 7*(128+BF_LAT) cycles: the last write is at cycle 6*(128+BF_LAT)+127+BF_LAT and done follows one cycle later.

Reset
REQ-030 While rst=0, the block SHALL hold: state IDLE, all outputs 0, counters 0, and the delay line cleared.
REQ-031 A reset asserted mid-transform SHALL force we1=we2=0 from assertion onward, with no pending writes issued after release; a subsequent start SHALL restart from stage 0.

Structure
REQ-032 Package ntt_pkg SHALL hold AWID=7, NPAIR=64, NSTAGE=7 and the FSM state enum.
REQ-033 The block SHALL contain one sub-module, addr_delay: a (1+BF_LAT)-deep shift register carrying {valid, A, B}, with asynchronous clear.

Verification (BF_LAT=4)
REQ-034 Reset: hold rst=0 for 3 cycles -> we1=we2=0, busy=0, done=0, A1radd=B1radd=0.
REQ-035 NTT: start with mode=0 -> cycle 0 A=0,B=64,we=0; cycle 1 rd_valid=1, tw_idx=1; cycle 2 A=1,B=65; cycle 5 A=0,B=64,we1=we2=1; cycle 132 A=0,B=32; cycle 133 tw_idx=2.
REQ-036 INTT: mode=1 -> cycle 0 A=0,B=1; cycle 1 tw_idx=127; cycle 2 A=2,B=3; cycle 3 tw_idx=126; stage 6 first read at cycle 792 with A=0,B=64 and tw_idx=1.
REQ-037 Completion: last write at cycle 923, done=1 only at cycle 924, busy=0 from cycle 924, IDLE by cycle 925.
REQ-038 Ignored start: pulse start=1 with mode=1 at cycle 300 of an NTT -> address/we trace identical to the undisturbed run.
REQ-039 Mid-op reset: rst=0 at cycle 400 -> we=0 immediately and no further writes; restart -> cycle 0 A=0,B=64.
